// File: rtl/cpu_sequencer_pkg.sv
// cpu_sequencer_pkg
// Shared constants for the CPU control sequencer: FSM state encodings
// (visible on the debug LEDs, so the numeric values are fixed) and the
// default program-counter width.
package cpu_sequencer_pkg;

  localparam int PC_W_DEFAULT = 8;

  localparam logic [2:0] ST_FETCH     = 3'd0;
  localparam logic [2:0] ST_LATCH     = 3'd1;
  localparam logic [2:0] ST_DECODE    = 3'd2;
  localparam logic [2:0] ST_EXEC      = 3'd3;
  localparam logic [2:0] ST_WB        = 3'd4;
  localparam logic [2:0] ST_WAIT_OP   = 3'd5;
  localparam logic [2:0] ST_WAIT_STEP = 3'd6;
  localparam logic [2:0] ST_HALT      = 3'd7;

endpackage

// File: rtl/cpu_sequencer.sv
// cpu_sequencer
// Multi-cycle control sequencer for the 16-bit CPU. Owns the PC, fetches from
// the synchronous instruction ROM, holds the instruction for the decoder,
// latches ALU flags, gates register-file writes and pauses on ShowR/LoadDip
// instructions or in single-step mode until the operator button is pressed.
//
// Ports:
//   i_CLK, i_RST_N        clock, asynchronous active-low reset
//   o_IMEM_ADDR           ROM address (= PC); i_IMEM_DATA valid one cycle later
//   o_INSTR               latched instruction for the decoder
//   i_SEL_JMP, i_IMM8     decoder jump decision and target
//   i_WriteBack(2)        decoder write-back requests
//   i_ShowR, i_DIP_REQ    operator-wait requests from the decoder
//   i_FLAG_UPD, i_ALU_*   flag update enable and combinational ALU flags
//   i_RUN, i_BTN_STEP     free-run/single-step select and step button pulse
//   o_Z/o_S/o_C/o_OF      latched flags
//   o_RF_WE, o_RF_WE2     one-cycle register-file write strobes (WB cycle)
//   o_SHOW, o_HALT        display hold, sticky halt
//   o_STATE               current FSM state for debug LEDs
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT
) (
  input  logic            i_CLK,
  input  logic            i_RST_N,
  output logic [PC_W-1:0] o_IMEM_ADDR,
  input  logic [15:0]     i_IMEM_DATA,
  output logic [15:0]     o_INSTR,
  input  logic            i_SEL_JMP,
  input  logic [7:0]      i_IMM8,
  input  logic            i_WriteBack,
  input  logic            i_WriteBack2,
  input  logic            i_ShowR,
  input  logic            i_DIP_REQ,
  input  logic            i_FLAG_UPD,
  input  logic            i_ALU_Z,
  input  logic            i_ALU_S,
  input  logic            i_ALU_C,
  input  logic            i_ALU_OF,
  input  logic            i_RUN,
  input  logic            i_BTN_STEP,
  output logic            o_Z,
  output logic            o_S,
  output logic            o_C,
  output logic            o_OF,
  output logic            o_RF_WE,
  output logic            o_RF_WE2,
  output logic            o_SHOW,
  output logic            o_HALT,
  output logic [2:0]      o_STATE
);

  logic [2:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     instr_q, instr_d;
  // Flag register packed as {Z, S, C, OF}.
  logic [3:0]      flags_q, flags_d;
  logic            rf_we_q, rf_we_d;
  logic            rf_we2_q, rf_we2_d;

  // Next-state, PC, instruction, flag and write-strobe logic.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    flags_d  = flags_q;
    rf_we_d  = 1'b0;
    rf_we2_d = 1'b0;
    case (state_q)
      ST_FETCH: begin
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        instr_d = i_IMEM_DATA;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        // ShowR and LoadDip together collapse into one operator wait.
        if (i_ShowR || i_DIP_REQ) begin
          state_d = ST_WAIT_OP;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_WAIT_OP: begin
        if (i_BTN_STEP) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_WAIT_OP;
        end
      end
      ST_EXEC: begin
        if (i_FLAG_UPD) begin
          flags_d = {i_ALU_Z, i_ALU_S, i_ALU_C, i_ALU_OF};
        end else begin
          flags_d = flags_q;
        end
        // Strobes are registered here so they are high exactly during WB;
        // o_INSTR is stable through WB so the request is the same one.
        rf_we_d  = i_WriteBack;
        rf_we2_d = i_WriteBack2;
        state_d  = ST_WB;
      end
      ST_WB: begin
        if (i_SEL_JMP) begin
          pc_d    = PC_W'(i_IMM8);
          state_d = i_RUN ? ST_FETCH : ST_WAIT_STEP;
        end else if (pc_q == {PC_W{1'b1}}) begin
          // Running off the end of ROM halts instead of wrapping to 0.
          pc_d    = pc_q;
          state_d = ST_HALT;
        end else begin
          pc_d    = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
          state_d = i_RUN ? ST_FETCH : ST_WAIT_STEP;
        end
      end
      ST_WAIT_STEP: begin
        if (i_BTN_STEP) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_WAIT_STEP;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q  <= ST_FETCH;
      pc_q     <= {PC_W{1'b0}};
      instr_q  <= 16'h0000;
      flags_q  <= 4'b0000;
      rf_we_q  <= 1'b0;
      rf_we2_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      flags_q  <= flags_d;
      rf_we_q  <= rf_we_d;
      rf_we2_q <= rf_we2_d;
    end
  end

  assign o_IMEM_ADDR = pc_q;
  assign o_INSTR     = instr_q;
  assign o_Z         = flags_q[3];
  assign o_S         = flags_q[2];
  assign o_C         = flags_q[1];
  assign o_OF        = flags_q[0];
  assign o_RF_WE     = rf_we_q;
  assign o_RF_WE2    = rf_we2_q;
  assign o_SHOW      = (state_q == ST_WAIT_OP) && i_ShowR;
  assign o_HALT      = (state_q == ST_HALT);
  assign o_STATE     = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer
// Self-checking bench for cpu_sequencer. A toy decoder maps instruction bits
// to decoder signals: [15] WriteBack, [14] WriteBack2, [13] ShowR, [12] DIP_REQ,
// [11] FLAG_UPD, [10] jump always, [9] jump if Z, [7:0] IMM8, and the ALU flags
// {Z,S,C,OF} are taken from [7:4]. The reference model tracks PC and flags per
// instruction and derives the expected state walk from the sequencing rules.
module tb_cpu_sequencer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [15:0] instr;
  logic        sel_jmp;
  logic [7:0]  imm8;
  logic        wb, wb2, showr, dip, fupd;
  logic        alu_z, alu_s, alu_c, alu_of;
  logic        run;
  logic        btn;
  logic        z, s, c, of;
  logic        rf_we, rf_we2, show, halt;
  logic [2:0]  state;

  logic [15:0] rom [256];
  logic [7:0]  m_pc;
  logic [3:0]  m_flags;
  int          checks;
  int          errors;

  cpu_sequencer #(.PC_W(8)) dut (
    .i_CLK(clk), .i_RST_N(rst_n),
    .o_IMEM_ADDR(imem_addr), .i_IMEM_DATA(imem_data), .o_INSTR(instr),
    .i_SEL_JMP(sel_jmp), .i_IMM8(imm8),
    .i_WriteBack(wb), .i_WriteBack2(wb2), .i_ShowR(showr), .i_DIP_REQ(dip),
    .i_FLAG_UPD(fupd), .i_ALU_Z(alu_z), .i_ALU_S(alu_s), .i_ALU_C(alu_c), .i_ALU_OF(alu_of),
    .i_RUN(run), .i_BTN_STEP(btn),
    .o_Z(z), .o_S(s), .o_C(c), .o_OF(of),
    .o_RF_WE(rf_we), .o_RF_WE2(rf_we2), .o_SHOW(show), .o_HALT(halt), .o_STATE(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction ROM.
  always @(posedge clk) imem_data <= rom[imem_addr];

  // Toy decoder and ALU.
  assign wb      = instr[15];
  assign wb2     = instr[14];
  assign showr   = instr[13];
  assign dip     = instr[12];
  assign fupd    = instr[11];
  assign sel_jmp = instr[10] | (instr[9] & z);
  assign imm8    = instr[7:0];
  assign alu_z   = instr[7];
  assign alu_s   = instr[6];
  assign alu_c   = instr[5];
  assign alu_of  = instr[4];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  task automatic do_reset();
    btn   = 1'b0;
    run   = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    m_pc    = 8'h00;
    m_flags = 4'h0;
  endtask

  // Runs one instruction from FETCH and checks every cycle against the model.
  task automatic step_instr(input bit run_i, input int op_wait, input int step_wait,
                            input bit btn_in_exec, output bit halted);
    logic [15:0] w;
    bit          jmp;
    w      = rom[m_pc];
    halted = 1'b0;
    run    = run_i;
    checks++;
    if (state !== 3'd0 || imem_addr !== m_pc) begin
      errors++;
      $display("FAIL fetch: state=%0d addr=%h, expected state=0 addr=%h", state, imem_addr, m_pc);
    end
    @(negedge clk);
    checks++;
    if (state !== 3'd1 || rf_we !== 1'b0 || rf_we2 !== 1'b0) begin
      errors++;
      $display("FAIL latch: state=%0d we=%b%b, expected state=1 we=00", state, rf_we, rf_we2);
    end
    @(negedge clk);
    checks++;
    if (state !== 3'd2 || instr !== w || rf_we !== 1'b0) begin
      errors++;
      $display("FAIL decode: state=%0d instr=%h we=%b, expected state=2 instr=%h we=0", state, instr, rf_we, w);
    end
    @(negedge clk);
    if (w[13] | w[12]) begin
      for (int i = 0; i <= op_wait; i++) begin
        checks++;
        if (state !== 3'd5 || show !== w[13] || rf_we !== 1'b0) begin
          errors++;
          $display("FAIL wait_op: state=%0d show=%b we=%b, expected state=5 show=%b we=0", state, show, rf_we, w[13]);
        end
        if (i < op_wait) @(negedge clk);
      end
      btn = 1'b1;
      @(negedge clk);
      btn = 1'b0;
    end
    checks++;
    if (state !== 3'd3 || show !== 1'b0 || rf_we !== 1'b0 || rf_we2 !== 1'b0 || {z, s, c, of} !== m_flags) begin
      errors++;
      $display("FAIL exec: state=%0d show=%b we=%b%b flags=%b, expected state=3 show=0 we=00 flags=%b",
               state, show, rf_we, rf_we2, {z, s, c, of}, m_flags);
    end
    if (btn_in_exec) btn = 1'b1;
    @(negedge clk);
    btn = 1'b0;
    if (w[11]) m_flags = w[7:4];
    jmp = w[10] | (w[9] & m_flags[3]);
    checks++;
    if (state !== 3'd4 || rf_we !== w[15] || rf_we2 !== w[14] || {z, s, c, of} !== m_flags) begin
      errors++;
      $display("FAIL wb: state=%0d we=%b%b flags=%b, expected state=4 we=%b%b flags=%b",
               state, rf_we, rf_we2, {z, s, c, of}, w[15], w[14], m_flags);
    end
    if (jmp) m_pc = w[7:0];
    else if (m_pc == 8'hFF) halted = 1'b1;
    else m_pc = m_pc + 8'd1;
    @(negedge clk);
    if (halted) begin
      checks++;
      if (state !== 3'd7 || halt !== 1'b1 || imem_addr !== 8'hFF || rf_we !== 1'b0) begin
        errors++;
        $display("FAIL halt: state=%0d halt=%b addr=%h we=%b, expected state=7 halt=1 addr=ff we=0",
                 state, halt, imem_addr, rf_we);
      end
    end else if (!run_i) begin
      for (int i = 0; i <= step_wait; i++) begin
        checks++;
        if (state !== 3'd6 || rf_we !== 1'b0 || rf_we2 !== 1'b0) begin
          errors++;
          $display("FAIL wait_step: state=%0d we=%b%b, expected state=6 we=00", state, rf_we, rf_we2);
        end
        if (i < step_wait) @(negedge clk);
      end
      btn = 1'b1;
      @(negedge clk);
      btn = 1'b0;
    end else begin
      checks++;
      if (rf_we !== 1'b0 || rf_we2 !== 1'b0) begin
        errors++;
        $display("FAIL strobe_len: we=%b%b, expected 00", rf_we, rf_we2);
      end
    end
  endtask

  task automatic test_reset();
    clear_rom();
    do_reset();
    checks++;
    if (state !== 3'd0 || imem_addr !== 8'h00 || instr !== 16'h0000 || {z, s, c, of} !== 4'h0 ||
        rf_we !== 1'b0 || rf_we2 !== 1'b0 || show !== 1'b0 || halt !== 1'b0) begin
      errors++;
      $display("FAIL reset: state=%0d addr=%h instr=%h flags=%b we=%b%b show=%b halt=%b, expected all zero",
               state, imem_addr, instr, {z, s, c, of}, rf_we, rf_we2, show, halt);
    end
  endtask

  task automatic test_free_run();
    bit h;
    clear_rom();
    rom[0] = 16'h8000;
    rom[1] = 16'h0000;
    do_reset();
    step_instr(1'b1, 0, 0, 1'b0, h);
    step_instr(1'b1, 0, 0, 1'b0, h);
    checks++;
    if (imem_addr !== 8'h02) begin
      errors++;
      $display("FAIL free_run_pc: addr=%h, expected 02", imem_addr);
    end
  endtask

  task automatic test_flags_jump();
    bit h;
    clear_rom();
    rom[0] = 16'h0880;
    rom[1] = 16'h8000;
    rom[2] = 16'h0220;
    do_reset();
    for (int i = 0; i < 3; i++) step_instr(1'b1, 0, 0, 1'b0, h);
    checks++;
    if (imem_addr !== 8'h20 || z !== 1'b1) begin
      errors++;
      $display("FAIL jump_eq: addr=%h z=%b, expected addr=20 z=1", imem_addr, z);
    end
  endtask

  task automatic test_show();
    bit h;
    clear_rom();
    rom[0] = 16'h2000;
    rom[1] = 16'hD000;
    do_reset();
    step_instr(1'b1, 50, 0, 1'b0, h);
    step_instr(1'b1, 3, 0, 1'b0, h);
  endtask

  task automatic test_step_mode();
    bit h;
    clear_rom();
    rom[0] = 16'h8000;
    rom[1] = 16'h4000;
    rom[2] = 16'h0000;
    do_reset();
    step_instr(1'b0, 0, 4, 1'b1, h);
    step_instr(1'b0, 0, 0, 1'b1, h);
    step_instr(1'b1, 0, 0, 1'b0, h);
  endtask

  task automatic test_halt();
    bit h;
    clear_rom();
    rom[0]     = 16'h04FF;
    rom[8'hFF] = 16'h8000;
    do_reset();
    step_instr(1'b1, 0, 0, 1'b0, h);
    step_instr(1'b1, 0, 0, 1'b0, h);
    checks++;
    if (h !== 1'b1) begin
      errors++;
      $display("FAIL halt_predict: model halted=%b, expected 1", h);
    end
    for (int i = 0; i < 6; i++) begin
      btn = i[0];
      @(negedge clk);
    end
    btn = 1'b0;
    checks++;
    if (state !== 3'd7 || halt !== 1'b1 || imem_addr !== 8'hFF) begin
      errors++;
      $display("FAIL halt_sticky: state=%0d halt=%b addr=%h, expected state=7 halt=1 addr=ff", state, halt, imem_addr);
    end
  endtask

  task automatic test_async_reset();
    bit h;
    clear_rom();
    rom[0] = 16'h08F0;
    rom[1] = 16'hC000;
    do_reset();
    step_instr(1'b1, 0, 0, 1'b0, h);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 3'd0 || imem_addr !== 8'h00 || instr !== 16'h0000 || {z, s, c, of} !== 4'h0 ||
        rf_we !== 1'b0 || rf_we2 !== 1'b0 || show !== 1'b0 || halt !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: state=%0d addr=%h instr=%h flags=%b we=%b%b, expected all zero",
               state, imem_addr, instr, {z, s, c, of}, rf_we, rf_we2);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    m_pc    = 8'h00;
    m_flags = 4'h0;
    @(negedge clk);
    checks++;
    if (state !== 3'd1 || rf_we !== 1'b0 || rf_we2 !== 1'b0) begin
      errors++;
      $display("FAIL restart: state=%0d we=%b%b, expected state=1 we=00", state, rf_we, rf_we2);
    end
  endtask

  task automatic test_random();
    bit          h;
    logic [15:0] w;
    for (int i = 0; i < 256; i++) begin
      w      = 16'($urandom);
      w[13]  = ($urandom_range(0, 7) == 0);
      w[12]  = ($urandom_range(0, 7) == 0);
      w[10]  = ($urandom_range(0, 9) == 0);
      w[9]   = ($urandom_range(0, 5) == 0);
      rom[i] = w;
    end
    do_reset();
    for (int n = 0; n < 120; n++) begin
      step_instr(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)), h);
      if (h) do_reset();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    btn    = 1'b0;
    run    = 1'b1;
    clear_rom();
    test_reset();
    test_free_run();
    test_flags_jump();
    test_show();
    test_step_mode();
    test_halt();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
